// File: rtl/cabin_chime_arbiter.sv
// Shares one cabin chime tone generator among fault, seatbelt, crew-call and
// passenger-call requesters: pulses are latched, served by fixed priority, chime then gap.
module cabin_chime_arbiter #(
  parameter int unsigned CHIME_CYCLES = 16,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       maintenance_mode,
  output logic       chime_active,
  output logic [1:0] chime_id,
  output logic [3:0] grant_pulse,
  output logic [3:0] pending,
  output logic [7:0] drop_count,
  output logic [1:0] state_debug
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned CW   = 8;
  localparam int unsigned DW   = 8;

  localparam logic [CW-1:0] CHIME_LOAD = CW'(CHIME_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
  localparam logic [DW-1:0] DROP_MAX   = {DW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHIME = 2'b01,
    GAP   = 2'b10
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;

  logic             win_valid;
  logic [IDW-1:0]   win_id;
  logic             grant_en;
  logic [IDW-1:0]   grant_idx;
  logic [NREQ-1:0]  grant_onehot;
  logic [NREQ-1:0]  requeue;
  logic [NREQ-1:0]  pend_nxt;
  logic [NREQ-1:0]  drops;
  logic [2:0]       drop_inc;
  logic [DW:0]      drop_sum;
  logic [DW-1:0]    drop_nxt;

  // Lowest-index pending request wins.
  always_comb begin
    win_valid = |pending;
    win_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pending[i]) win_id = IDW'(i);
    end
  end

  // Grant decision: normal grant from IDLE/GAP-end, or fault preemption of a running chime.
  always_comb begin
    grant_en  = 1'b0;
    grant_idx = win_id;
    requeue   = '0;
    if (!maintenance_mode) begin
      unique case (state)
        IDLE:  grant_en = win_valid;
        CHIME: begin
          if (chime_id != '0 && pending[0]) begin
            grant_en          = 1'b1;
            grant_idx         = '0;
            requeue[chime_id] = 1'b1;
          end
        end
        GAP:   grant_en = (cnt == '0) && win_valid;
        default: grant_en = 1'b0;
      endcase
    end
    grant_onehot = grant_en ? (NREQ'(1) << grant_idx) : '0;
  end

  // Pending latch (set beats clear) and saturating coalesced-request counter.
  always_comb begin
    pend_nxt = req | (pending & ~grant_onehot) | requeue;
    drops    = req & pending & ~grant_onehot;
    drop_inc = 3'(drops[0]) + 3'(drops[1]) + 3'(drops[2]) + 3'(drops[3]);
    drop_sum = {1'b0, drop_count} + (DW+1)'(drop_inc);
    drop_nxt = (drop_sum > (DW+1)'(DROP_MAX)) ? DROP_MAX : drop_sum[DW-1:0];
  end

  // Chime sequencer; maintenance freezes everything except the pending latch and drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      chime_active <= 1'b0;
      chime_id     <= '0;
      grant_pulse  <= '0;
      pending      <= '0;
      drop_count   <= '0;
    end else begin
      pending     <= pend_nxt;
      drop_count  <= drop_nxt;
      grant_pulse <= '0;
      if (grant_en) begin
        state        <= CHIME;
        cnt          <= CHIME_LOAD;
        chime_active <= 1'b1;
        chime_id     <= grant_idx;
        grant_pulse  <= grant_onehot;
      end else if (!maintenance_mode) begin
        unique case (state)
          CHIME: begin
            if (cnt == '0) begin
              state        <= GAP;
              cnt          <= GAP_LOAD;
              chime_active <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          GAP: begin
            if (cnt == '0) begin
              state <= IDLE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign state_debug = 2'(state);

endmodule
